// File: rtl/datapath_ctrl_if.sv
// Handshake and datapath-control bundle between an instruction source,
// the datapath_ctrl sequencer and the Lab 5 datapath.
interface datapath_ctrl_if;
  logic        start;
  logic [15:0] instr;
  logic        w;
  logic        done;
  logic        err;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic        loadc;
  logic        loads;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] datapath_in;

  // Controller side: takes the instruction, drives every datapath control.
  modport master (
    input  start, instr,
    output w, done, err, readnum, writenum, write, vsel, loada, loadb,
           asel, bsel, loadc, loads, shift, ALUop, datapath_in
  );

  // Environment side: instruction source plus the datapath it steers.
  modport slave (
    output start, instr,
    input  w, done, err, readnum, writenum, write, vsel, loada, loadb,
           asel, bsel, loadc, loads, shift, ALUop, datapath_in
  );
endinterface

// File: rtl/datapath_ctrl.sv
// Moore-style instruction sequencer for the Lab 5 datapath: latches one
// instruction on start, then steps the datapath controls through a fixed schedule.
module datapath_ctrl (
  input  logic           clk,
  input  logic           reset_n,
  datapath_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WIMM, S_LDA, S_LDB, S_EXEC, S_WRC
  } state_t;

  typedef enum logic [2:0] {
    I_MOVI, I_MOVR, I_ADD, I_CMP, I_AND, I_MVN, I_ILL
  } kind_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  kind_t       kind;

  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;

  assign op = ir_q[12:11];
  assign rn = ir_q[10:8];
  assign rd = ir_q[7:5];
  assign sh = ir_q[4:3];
  assign rm = ir_q[2:0];

  always_comb begin
    kind = I_ILL;
    case ({ir_q[15:13], ir_q[12:11]})
      5'b110_10: kind = I_MOVI;
      5'b110_00: kind = I_MOVR;
      5'b101_00: kind = I_ADD;
      5'b101_01: kind = I_CMP;
      5'b101_10: kind = I_AND;
      5'b101_11: kind = I_MVN;
      default:   kind = I_ILL;
    endcase
  end

  // IR only moves on an accepted start, so instr may change freely while busy.
  always_comb begin
    ir_d = ir_q;
    if (state_q == S_IDLE && bus.start) ir_d = bus.instr;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign bus.datapath_in = {{8{ir_q[7]}}, ir_q[7:0]};

  // NOTE: every output gets a default before the case so no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    bus.w        = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    bus.readnum  = 3'd0;
    bus.writenum = 3'd0;
    bus.write    = 1'b0;
    bus.vsel     = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.shift    = 2'b00;
    bus.ALUop    = 2'b00;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.w = 1'b1;
        if (bus.start) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.err = (kind == I_ILL);
        case (kind)
          I_MOVI:              state_d = S_WIMM;
          I_MOVR, I_MVN:       state_d = S_LDB;
          I_ADD, I_CMP, I_AND: state_d = S_LDA;
          default:             state_d = S_IDLE;
        endcase
      end
      S_WIMM: begin
        bus.vsel     = 1'b1;
        bus.writenum = rn;
        bus.write    = 1'b1;
        bus.done     = 1'b1;
        state_d      = S_IDLE;
      end
      S_LDA: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
        state_d     = S_LDB;
      end
      S_LDB: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        // MOV-reg and MVN force A to zero so the ALU sees only the shifted B.
        bus.shift = sh;
        bus.asel  = (kind == I_MOVR) || (kind == I_MVN);
        bus.ALUop = (kind == I_MOVR) ? 2'b00 : op;
        bus.loadc = (kind != I_CMP);
        bus.loads = (kind == I_CMP);
        bus.done  = (kind == I_CMP);
        state_d   = (kind == I_CMP) ? S_IDLE : S_WRC;
      end
      S_WRC: begin
        bus.writenum = rd;
        bus.write    = 1'b1;
        bus.done     = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
